// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU fetch/data memory arbiter: FSM states, grant ids,
// and the starvation-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } gnt_e;

    // Bits needed to count 0..limit inclusive.
    function automatic int unsigned starve_w(input int unsigned limit);
        return unsigned'($clog2(limit + 1));
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision between fetch and data: data has priority until fetch has
// lost STARVE_LIMIT arbitrations in a row, then fetch is forced through.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic arb,
    output logic req_any_c,
    output gnt_e gnt_c
);

    localparam int unsigned SW = starve_w(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          at_limit_c;

    assign at_limit_c = (starve_cnt == SW'(STARVE_LIMIT));
    assign req_any_c  = if_req | d_req;
    assign gnt_c      = (if_req && (!d_req || at_limit_c)) ? GNT_IF : GNT_D;

    // Counts data wins that happen while fetch is waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (arb) begin
            if (!if_req || gnt_c == GNT_IF) begin
                starve_cnt <= '0;
            end else if (!at_limit_c) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU fetch and load/store requests onto one single-port memory,
// holding strobes for MEM_LATENCY cycles and returning a one-cycle ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_e           state;
    gnt_e             gnt_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic             req_any_c;
    gnt_e             gnt_c;

    mem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .d_req    (d_req),
        .arb      (state == ST_IDLE),
        .req_any_c(req_any_c),
        .gnt_c    (gnt_c)
    );

    // mem_addr/mem_wdata double as the request latches for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_q     <= GNT_IF;
            we_q      <= 1'b0;
            cnt       <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any_c) begin
                        gnt_q <= gnt_c;
                        cnt   <= CNT_W'(MEM_LATENCY - 1);
                        state <= ST_BUSY;
                        if (gnt_c == GNT_IF) begin
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            we_q      <= 1'b0;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            we_q      <= d_we;
                            mem_read  <= !d_we;
                            mem_write <= d_we;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ST_DONE;
                        if (gnt_q == GNT_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!we_q) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-vector table for fetch/load/store/
// collision, plus sequences for starvation, reset mid-access and latency sweep.
module tb_mem_arbiter;

    typedef logic [135:0] w_t;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic [1:0]  ack;
        logic [1:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] if_rd;
        logic [31:0] d_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, d_ack, mem_read, mem_write;
    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_if_ack, l1_d_ack, l1_mem_read, l1_mem_write;
    logic [31:0] l5_if_rdata, l5_d_rdata, l5_mem_addr, l5_mem_wdata;
    logic        l5_if_ack, l5_d_ack, l5_mem_read, l5_mem_write;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(2)) u_dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)) u_l1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(l1_if_rdata),
        .if_ack(l1_if_ack), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(l1_d_rdata), .d_ack(l1_d_ack), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_read(l1_mem_read), .mem_write(l1_mem_write), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(5), .STARVE_LIMIT(2)) u_l5 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(l5_if_rdata),
        .if_ack(l5_if_ack), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(l5_d_rdata), .d_ack(l5_d_ack), .mem_addr(l5_mem_addr), .mem_wdata(l5_mem_wdata),
        .mem_read(l5_mem_read), .mem_write(l5_mem_write), .mem_rdata(mem_rdata)
    );

    always @(negedge clk) begin
        if (rst === 1'b0 && if_ack === 1'b1 && d_ack === 1'b1) overlap++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic w_t obs();
        return w_t'({if_ack, d_ack, mem_read, mem_write, mem_addr, mem_wdata, if_rdata, d_rdata});
    endfunction

    function automatic vec_t mk(logic ifr, logic [31:0] ifa, logic dr, logic dwe,
                                logic [31:0] da, logic [31:0] dwd, logic [31:0] mrd,
                                logic [1:0] ack, logic [1:0] strb, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] ifrd, logic [31:0] drd);
        vec_t v;
        v.if_req = ifr;  v.if_addr = ifa; v.d_req = dr;  v.d_we = dwe;
        v.d_addr = da;   v.d_wdata = dwd; v.mem_rdata = mrd;
        v.ack = ack;     v.strb = strb;   v.addr = addr; v.wdata = wd;
        v.if_rd = ifrd;  v.d_rd = drd;
        return v;
    endfunction

    // Returns 1 for fetch ack, 2 for data ack, 3 if both, 0 on timeout.
    task automatic wait_any_ack(input int max_cycles, output int who, output int cycles);
        who = 0;
        cycles = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge clk); #1;
            if (if_ack === 1'b1 || d_ack === 1'b1) begin
                who = (if_ack === 1'b1 ? 1 : 0) + (d_ack === 1'b1 ? 2 : 0);
                cycles = i;
                break;
            end
        end
    endtask

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'hCAFEF00D;
    localparam logic [31:0] K1 = 32'h11111111;
    localparam logic [31:0] K2 = 32'h22222222;
    localparam logic [31:0] K5 = 32'h55555555;

    initial begin
        vec_t tbl[$];
        int   who, cyc, acks_seen;
        int   l1_str, l5_str, l1_ack, l5_ack;
        logic [31:0] l1_rd, l5_rd;
        int   exp_order[6];

        // Fetch 0x10, load 0x30, store 0x20, then simultaneous fetch 0x40 / load 0x50.
        tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, 0,             2'b00, 2'b10, 32'h10, 0, 0, 0));
        tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, DB,            2'b00, 2'b10, 32'h10, 0, 0, 0));
        tbl.push_back(mk(1, 32'h10, 0, 0, 0, 0, DB,            2'b10, 2'b00, 32'h10, 0, DB, 0));
        tbl.push_back(mk(0, 32'h10, 0, 0, 0, 0, 0,             2'b00, 2'b00, 32'h10, 0, DB, 0));
        tbl.push_back(mk(0, 32'h10, 1, 0, 32'h30, 0, 0,        2'b00, 2'b10, 32'h30, 0, DB, 0));
        tbl.push_back(mk(0, 32'h10, 1, 0, 32'h30, 0, CF,       2'b00, 2'b10, 32'h30, 0, DB, 0));
        tbl.push_back(mk(0, 32'h10, 1, 0, 32'h30, 0, CF,       2'b01, 2'b00, 32'h30, 0, DB, CF));
        tbl.push_back(mk(0, 32'h10, 0, 0, 32'h30, 0, 0,        2'b00, 2'b00, 32'h30, 0, DB, CF));
        tbl.push_back(mk(0, 32'h10, 1, 1, 32'h20, 32'h1234, K5, 2'b00, 2'b01, 32'h20, 32'h1234, DB, CF));
        tbl.push_back(mk(0, 32'h10, 1, 1, 32'h20, 32'h1234, K5, 2'b00, 2'b01, 32'h20, 32'h1234, DB, CF));
        tbl.push_back(mk(0, 32'h10, 1, 1, 32'h20, 32'h1234, K5, 2'b01, 2'b00, 32'h20, 32'h1234, DB, CF));
        tbl.push_back(mk(0, 32'h10, 0, 0, 32'h20, 32'h1234, K5, 2'b00, 2'b00, 32'h20, 32'h1234, DB, CF));
        tbl.push_back(mk(1, 32'h40, 1, 0, 32'h50, 0, K1,       2'b00, 2'b10, 32'h50, 0, DB, CF));
        tbl.push_back(mk(1, 32'h40, 1, 0, 32'h50, 0, K1,       2'b00, 2'b10, 32'h50, 0, DB, CF));
        tbl.push_back(mk(1, 32'h40, 1, 0, 32'h50, 0, K1,       2'b01, 2'b00, 32'h50, 0, DB, K1));
        tbl.push_back(mk(1, 32'h40, 0, 0, 32'h50, 0, K2,       2'b00, 2'b00, 32'h50, 0, DB, K1));
        tbl.push_back(mk(1, 32'h40, 0, 0, 32'h50, 0, K2,       2'b00, 2'b10, 32'h40, 0, DB, K1));
        tbl.push_back(mk(1, 32'h40, 0, 0, 32'h50, 0, K2,       2'b00, 2'b10, 32'h40, 0, DB, K1));
        tbl.push_back(mk(1, 32'h40, 0, 0, 32'h50, 0, K2,       2'b10, 2'b00, 32'h40, 0, K2, K1));
        tbl.push_back(mk(0, 32'h40, 0, 0, 32'h50, 0, 0,        2'b00, 2'b00, 32'h40, 0, K2, K1));

        // Reset state.
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs(), w_t'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
            d_req = tbl[i].d_req;   d_we = tbl[i].d_we;
            d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
            mem_rdata = tbl[i].mem_rdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), obs(),
                  w_t'({tbl[i].ack, tbl[i].strb, tbl[i].addr, tbl[i].wdata, tbl[i].if_rd, tbl[i].d_rd}));
        end

        // Starvation: both requesters held continuously, limit 2.
        exp_order = '{2, 2, 1, 2, 2, 1};
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90; mem_rdata = 32'h0;
        for (int g = 0; g < 6; g++) begin
            wait_any_ack(12, who, cyc);
            check($sformatf("starve_grant%0d", g), w_t'(who), w_t'(exp_order[g]));
            @(posedge clk); #1;
            check($sformatf("starve_ackpulse%0d", g), w_t'({if_ack, d_ack}), w_t'(0));
        end
        @(negedge clk);
        drive_idle();

        // Reset during the second BUSY cycle of a load.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; mem_rdata = 32'h66666666;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy2_read", w_t'({mem_read, mem_addr}), w_t'({1'b1, 32'h60}));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", obs(), w_t'(0));
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        acks_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (d_ack === 1'b1 || mem_read === 1'b1) acks_seen++;
        end
        check("rst_no_ack", w_t'(acks_seen), w_t'(0));
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h70; mem_rdata = 32'h77777777;
        wait_any_ack(10, who, cyc);
        check("post_rst_fetch", w_t'({who, cyc, if_rdata}), w_t'({32'd1, 32'd3, 32'h77777777}));
        @(negedge clk);
        drive_idle();

        // Latency sweep on the MEM_LATENCY=1 and =5 instances.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'h0BADF00D;
        l1_str = 0; l5_str = 0; l1_ack = 0; l5_ack = 0; l1_rd = '0; l5_rd = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (l1_ack == 0) begin
                if (l1_mem_read === 1'b1) l1_str++;
                if (l1_if_ack === 1'b1) begin l1_ack = k; l1_rd = l1_if_rdata; end
            end
            if (l5_ack == 0) begin
                if (l5_mem_read === 1'b1) l5_str++;
                if (l5_if_ack === 1'b1) begin l5_ack = k; l5_rd = l5_if_rdata; end
            end
        end
        @(negedge clk);
        drive_idle();
        check("lat1_strobe_width", w_t'(l1_str), w_t'(1));
        check("lat1_ack_cycle", w_t'(l1_ack), w_t'(2));
        check("lat1_rdata", w_t'(l1_rd), w_t'(32'h0BADF00D));
        check("lat5_strobe_width", w_t'(l5_str), w_t'(5));
        check("lat5_ack_cycle", w_t'(l5_ack), w_t'(6));
        check("lat5_rdata", w_t'(l5_rd), w_t'(32'h0BADF00D));
        repeat (10) @(posedge clk);

        check("ack_overlap", w_t'(overlap), w_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
